// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding memory request feeding a 2-entry response FIFO.
// Optional misaligned-redirect trap is enabled by defining FETCH_ALIGN_CHECK_EN (adds adel_out).
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_out,
  output logic [31:0] pc4_out,
  output logic        instr_valid
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        adel_out
`endif
);

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic [31:0] pc_q, pc_d;
  logic        outstanding_q, outstanding_d;
  logic        drop_q, drop_d;
  logic        halt_q, halt_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [31:0] instr_mem_q [2];
  logic [31:0] instr_mem_d [2];
  logic [31:0] pc4_mem_q [2];
  logic [31:0] pc4_mem_d [2];

  logic        busy, resp_fire, push, pop, handshake, misalign;
  logic [1:0]  occ_after;
  logic [1:0]  entry_we;
  logic [31:0] redirect_target, wr_instr, wr_pc4;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redirect_target = redirect_pc;
  assign misalign        = redirect & (redirect_pc[1:0] != 2'b00);
  assign imem_addr       = pc_q;
`else
  logic unused_redirect_lsbs;
  assign redirect_target      = {redirect_pc[31:2], 2'b00};
  assign misalign             = 1'b0;
  assign unused_redirect_lsbs = |redirect_pc[1:0];
  assign imem_addr            = {pc_q[31:2], 2'b00};
`endif

  // The response landing this cycle frees the single request slot, so the next
  // request may go out in the same cycle; the occupancy credit accounts for it.
  assign busy        = outstanding_q & ~imem_rvalid;
  assign resp_fire   = outstanding_q & imem_rvalid;
  assign push        = resp_fire & ~drop_q & ~redirect;
  assign instr_valid = (count_q != 2'd0);
  assign pop         = instr_valid & ~stall & ~redirect;
  assign occ_after   = count_q + {1'b0, push} - {1'b0, pop};
  assign imem_req    = ~reset & ~redirect & ~busy & ~drop_q & ~halt_q & (occ_after < 2'd2);
  assign handshake   = imem_req & imem_gnt;

  assign instr_out = instr_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign pc4_out   = instr_valid ? pc4_mem_q[rd_ptr_q] : pc_q + 32'd4;

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    halt_d        = halt_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    if (redirect) begin
      // A response still in flight belongs to the old path and must be swallowed.
      pc_d          = redirect_target;
      outstanding_d = busy;
      drop_d        = busy;
      halt_d        = misalign;
      count_d       = misalign ? 2'd1 : 2'd0;
      rd_ptr_d      = 1'b0;
      wr_ptr_d      = misalign;
    end else begin
      if (handshake) begin
        pc_d          = pc_q + 32'd4;
        outstanding_d = 1'b1;
      end else if (resp_fire) begin
        outstanding_d = 1'b0;
      end
      if (resp_fire) drop_d = 1'b0;
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = occ_after;
    end
  end

  // pc_q already equals request address + 4 while its response is pending.
  assign wr_instr = misalign ? 32'h0 : imem_rdata;
  assign wr_pc4   = misalign ? redirect_pc + 32'd4 : pc_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry_we
    assign entry_we[gi] = redirect ? ((gi == 0) && misalign)
                                   : (push && (wr_ptr_q == 1'(gi)));
  end

  always_comb begin
    instr_mem_d = instr_mem_q;
    pc4_mem_d   = pc4_mem_q;
    for (int i = 0; i < 2; i++) begin
      if (entry_we[i]) begin
        instr_mem_d[i] = wr_instr;
        pc4_mem_d[i]   = wr_pc4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      halt_q        <= 1'b0;
      count_q       <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        instr_mem_q[i] <= 32'h0;
        pc4_mem_q[i]   <= 32'h0;
      end
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      halt_q        <= halt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      instr_mem_q   <= instr_mem_d;
      pc4_mem_q     <= pc4_mem_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic adel_mem_q [2];
  logic adel_mem_d [2];

  always_comb begin
    adel_mem_d = adel_mem_q;
    for (int i = 0; i < 2; i++) begin
      if (entry_we[i]) adel_mem_d[i] = misalign;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) adel_mem_q[i] <= 1'b0;
    end else begin
      adel_mem_q <= adel_mem_d;
    end
  end

  assign adel_out = instr_valid & adel_mem_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit: memory responder plus a sequential-address
// reference model (instructions must appear in address order from the last reset/redirect).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, imem_req, imem_gnt, imem_rvalid, stall, redirect, instr_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr_out, pc4_out;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        adel_out;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_out(instr_out), .pc4_out(pc4_out), .instr_valid(instr_valid)
`ifdef FETCH_ALIGN_CHECK_EN
    , .adel_out(adel_out)
`endif
  );

  typedef struct {
    logic        req, hs, iv, popped, adel;
    logic [31:0] addr, instr, pc4;
  } obs_t;

  int n_assert = 0, n_fail = 0;
  int gnt_mode = 1, lat_min = 0, lat_max = 0;
  int proto_err = 0, hold_err = 0, bubble_err = 0;
  bit mem_busy = 0;
  int mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  bit prev_pend = 0;
  logic [31:0] prev_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle: drive inputs at negedge, sample 1 time unit later, advance memory at posedge.
  task automatic tick(input logic rst, input logic st, input logic rd, input logic [31:0] rpc,
                      output obs_t o);
    @(negedge clk);
    reset = rst; stall = st; redirect = rd; redirect_pc = rpc;
    imem_rvalid = mem_busy && (mem_cnt == 0);
    imem_rdata  = imem_rvalid ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    case (gnt_mode)
      0:       imem_gnt = 1'b0;
      1:       imem_gnt = 1'b1;
      default: imem_gnt = 1'($urandom_range(0, 1));
    endcase
    #1;
    o.req = imem_req; o.hs = imem_req & imem_gnt; o.addr = imem_addr;
    o.iv = instr_valid; o.instr = instr_out; o.pc4 = pc4_out;
    o.popped = instr_valid & ~stall & ~redirect & ~reset;
`ifdef FETCH_ALIGN_CHECK_EN
    o.adel = adel_out;
`else
    o.adel = 1'b0;
`endif
    if (o.hs && ((mem_busy && !imem_rvalid) || imem_addr[1:0] != 2'b00)) proto_err++;
    if (prev_pend && !rd && !rst && (!imem_req || imem_addr != prev_addr)) hold_err++;
    if (instr_valid === 1'b0 && instr_out !== 32'h0) bubble_err++;
    prev_pend = imem_req && !imem_gnt;
    prev_addr = imem_addr;
    @(posedge clk);
    if (rst) begin
      mem_busy = 0;
    end else begin
      if (imem_rvalid) mem_busy = 0;
      else if (mem_busy) mem_cnt--;
      if (o.hs) begin
        mem_busy = 1; mem_addr = o.addr; mem_cnt = $urandom_range(lat_min, lat_max);
      end
    end
  endtask

  task automatic apply_reset();
    obs_t o;
    tick(1, 0, 0, 32'h0, o);
    tick(1, 0, 0, 32'h0, o);
  endtask

  task automatic test_reset();
    obs_t o;
    gnt_mode = 2; lat_min = 0; lat_max = 2;
    apply_reset();
    for (int c = 0; c < 6; c++) tick(0, 0, 0, 32'h0, o);
    tick(1, 0, 1, 32'h0000_8000, o);
    tick(1, 0, 1, 32'h0000_8000, o);
    n_assert++; if (o.req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", o.req); end
    n_assert++; if (o.iv !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o.iv); end
    n_assert++; if (o.instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", o.instr); end
    n_assert++; if (o.pc4 !== 32'h3004) begin n_fail++; $display("FAIL reset_pc4: got %h expected 00003004", o.pc4); end
    gnt_mode = 0;
    tick(0, 0, 0, 32'h0, o);
    n_assert++;
    if (o.req !== 1'b1 || o.addr !== 32'h3000) begin
      n_fail++; $display("FAIL first_req: req=%b addr=%h expected req=1 addr=00003000", o.req, o.addr);
    end
  endtask

  task automatic test_stream();
    obs_t o;
    logic [31:0] exp_pc = 32'h3000;
    int first_pop = -1;
    gnt_mode = 1; lat_min = 0; lat_max = 0;
    apply_reset();
    for (int c = 0; c < 14; c++) begin
      tick(0, 0, 0, 32'h0, o);
      if (c >= 2) begin
        n_assert++; if (o.popped !== 1'b1) begin n_fail++; $display("FAIL stream_gap: cycle %0d valid=%b expected 1", c, o.iv); end
      end
      if (o.popped) begin
        if (first_pop < 0) first_pop = c;
        n_assert++;
        if (o.instr !== mem_word(exp_pc) || o.pc4 !== exp_pc + 32'd4) begin
          n_fail++; $display("FAIL stream_data: instr=%h pc4=%h expected instr=%h pc4=%h", o.instr, o.pc4, mem_word(exp_pc), exp_pc + 32'd4);
        end
        exp_pc += 32'd4;
      end
    end
    n_assert++; if (first_pop !== 2) begin n_fail++; $display("FAIL stream_latency: first valid cycle %0d expected 2", first_pop); end
  endtask

  task automatic test_stall();
    obs_t o;
    logic [31:0] exp_pc = 32'h3000;
    logic [31:0] held = 32'h0;
    int pops = 0;
    gnt_mode = 1; lat_min = 0; lat_max = 0;
    apply_reset();
    for (int c = 0; c < 25; c++) begin
      logic st;
      st = (c >= 6 && c < 11);
      tick(0, st, 0, 32'h0, o);
      if (c == 6) begin
        held = o.instr;
        n_assert++; if (o.iv !== 1'b1) begin n_fail++; $display("FAIL stall_start_valid: got %b expected 1", o.iv); end
      end
      if (c == 10) begin
        n_assert++;
        if (o.req !== 1'b0 || o.iv !== 1'b1 || o.instr !== held) begin
          n_fail++; $display("FAIL stall_full: req=%b valid=%b instr=%h expected req=0 valid=1 instr=%h", o.req, o.iv, o.instr, held);
        end
      end
      if (o.popped) begin
        pops++;
        n_assert++;
        if (o.instr !== mem_word(exp_pc) || o.pc4 !== exp_pc + 32'd4) begin
          n_fail++; $display("FAIL stall_order: instr=%h pc4=%h expected instr=%h pc4=%h", o.instr, o.pc4, mem_word(exp_pc), exp_pc + 32'd4);
        end
        exp_pc += 32'd4;
      end
    end
    n_assert++; if (pops < 15) begin n_fail++; $display("FAIL stall_throughput: pops=%0d expected at least 15", pops); end
  endtask

  task automatic test_gnt_low();
    obs_t o;
    logic [31:0] exp_pc = 32'h3000;
    int pops = 0;
    gnt_mode = 0; lat_min = 0; lat_max = 0;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      tick(0, 0, 0, 32'h0, o);
      n_assert++;
      if (o.req !== 1'b1 || o.addr !== 32'h3000 || o.iv !== 1'b0 || o.instr !== 32'h0) begin
        n_fail++; $display("FAIL gnt_low: req=%b addr=%h valid=%b instr=%h expected 1/00003000/0/00000000", o.req, o.addr, o.iv, o.instr);
      end
    end
    gnt_mode = 1;
    for (int c = 0; c < 8; c++) begin
      tick(0, 0, 0, 32'h0, o);
      if (o.popped) begin
        pops++;
        n_assert++;
        if (o.instr !== mem_word(exp_pc) || o.pc4 !== exp_pc + 32'd4) begin
          n_fail++; $display("FAIL gnt_resume: instr=%h pc4=%h expected instr=%h pc4=%h", o.instr, o.pc4, mem_word(exp_pc), exp_pc + 32'd4);
        end
        exp_pc += 32'd4;
      end
    end
    n_assert++; if (pops < 1) begin n_fail++; $display("FAIL gnt_resume_timeout: pops=%0d expected >=1", pops); end
  endtask

  task automatic test_redirect_outstanding();
    obs_t o;
    logic [31:0] exp_pc = 32'h3000;
    bit found = 0, got = 0;
    gnt_mode = 1; lat_min = 2; lat_max = 2;
    apply_reset();
    for (int c = 0; c < 30 && !found; c++) begin
      tick(0, 0, 0, 32'h0, o);
      if (o.hs && o.addr == 32'h3008) found = 1;
      if (o.popped) exp_pc += 32'd4;
    end
    n_assert++; if (!found) begin n_fail++; $display("FAIL redir_setup: grant for 00003008 seen=%0d expected 1", found); end
    tick(0, 0, 1, 32'h4000, o);
    tick(0, 0, 0, 32'h0, o);
    n_assert++; if (o.iv !== 1'b0) begin n_fail++; $display("FAIL redir_bubble: valid=%b expected 0", o.iv); end
    for (int c = 0; c < 30 && !got; c++) begin
      tick(0, 0, 0, 32'h0, o);
      if (o.popped) begin
        got = 1;
        n_assert++;
        if (o.instr !== mem_word(32'h4000) || o.pc4 !== 32'h4004) begin
          n_fail++; $display("FAIL redir_first: instr=%h pc4=%h expected instr=%h pc4=00004004", o.instr, o.pc4, mem_word(32'h4000));
        end
      end
    end
    n_assert++; if (!got) begin n_fail++; $display("FAIL redir_timeout: valid seen=%0d expected 1", got); end
  endtask

  task automatic test_wrap();
    obs_t o;
    logic [31:0] exp_pc = 32'hFFFF_FFFC;
    logic [31:0] pc4_seen [2];
    int pops = 0;
    gnt_mode = 1; lat_min = 0; lat_max = 1;
    apply_reset();
    tick(0, 0, 0, 32'h0, o);
    tick(0, 0, 1, 32'hFFFF_FFFC, o);
    for (int c = 0; c < 20; c++) begin
      tick(0, 0, 0, 32'h0, o);
      if (o.popped) begin
        if (pops < 2) pc4_seen[pops] = o.pc4;
        pops++;
        n_assert++;
        if (o.instr !== mem_word(exp_pc) || o.pc4 !== exp_pc + 32'd4) begin
          n_fail++; $display("FAIL wrap_data: instr=%h pc4=%h expected instr=%h pc4=%h", o.instr, o.pc4, mem_word(exp_pc), exp_pc + 32'd4);
        end
        exp_pc += 32'd4;
      end
    end
    n_assert++;
    if (pops < 2 || pc4_seen[0] !== 32'h0 || pc4_seen[1] !== 32'h4) begin
      n_fail++; $display("FAIL wrap_pc4: pops=%0d first pc4=%h second pc4=%h expected 00000000 00000004", pops, pc4_seen[0], pc4_seen[1]);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    bit got = 0;
    gnt_mode = 2; lat_min = 0; lat_max = 2;
    apply_reset();
    for (int c = 0; c < 5; c++) tick(0, 0, 0, 32'h0, o);
    tick(0, 0, 1, 32'h6000, o);
    tick(0, 0, 1, 32'h7000, o);
    for (int c = 0; c < 40 && !got; c++) begin
      tick(0, 0, 0, 32'h0, o);
      if (o.popped) begin
        got = 1;
        n_assert++;
        if (o.instr !== mem_word(32'h7000) || o.pc4 !== 32'h7004) begin
          n_fail++; $display("FAIL b2b_redirect: instr=%h pc4=%h expected instr=%h pc4=00007004", o.instr, o.pc4, mem_word(32'h7000));
        end
      end
    end
    n_assert++; if (!got) begin n_fail++; $display("FAIL b2b_timeout: valid seen=%0d expected 1", got); end
  endtask

  task automatic test_random();
    obs_t o;
    logic [31:0] exp_pc = 32'h3000;
    int pops = 0;
    gnt_mode = 2; lat_min = 0; lat_max = 3;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      logic rst, st, rd;
      logic [31:0] rpc;
      rst = ($urandom_range(0, 299) == 0);
      st  = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 39) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
`ifdef FETCH_ALIGN_CHECK_EN
      rpc = rpc & 32'hFFFF_FFFC;
`endif
      tick(rst, st, rd, rpc, o);
      if (rst) exp_pc = 32'h3000;
      else if (rd) exp_pc = rpc & 32'hFFFF_FFFC;
      else if (o.popped) begin
        pops++;
        n_assert++;
        if (o.instr !== mem_word(exp_pc) || o.pc4 !== exp_pc + 32'd4) begin
          n_fail++; $display("FAIL random_data: cycle %0d instr=%h pc4=%h expected instr=%h pc4=%h", c, o.instr, o.pc4, mem_word(exp_pc), exp_pc + 32'd4);
        end
        exp_pc += 32'd4;
      end
    end
    n_assert++; if (pops < 300) begin n_fail++; $display("FAIL random_progress: pops=%0d expected >=300", pops); end
  endtask

`ifdef FETCH_ALIGN_CHECK_EN
  task automatic test_align();
    obs_t o;
    bit got = 0;
    gnt_mode = 1; lat_min = 0; lat_max = 0;
    apply_reset();
    for (int c = 0; c < 4; c++) tick(0, 0, 0, 32'h0, o);
    tick(0, 0, 1, 32'h4002, o);
    tick(0, 1, 0, 32'h0, o);
    n_assert++;
    if (o.req !== 1'b0 || o.iv !== 1'b1 || o.instr !== 32'h0 || o.adel !== 1'b1 || o.pc4 !== 32'h4006) begin
      n_fail++; $display("FAIL adel_entry: req=%b valid=%b instr=%h adel=%b pc4=%h expected 0/1/00000000/1/00004006", o.req, o.iv, o.instr, o.adel, o.pc4);
    end
    tick(0, 0, 0, 32'h0, o);
    for (int c = 0; c < 3; c++) begin
      tick(0, 0, 0, 32'h0, o);
      n_assert++;
      if (o.req !== 1'b0 || o.iv !== 1'b0) begin
        n_fail++; $display("FAIL adel_halt: req=%b valid=%b expected 0/0", o.req, o.iv);
      end
    end
    tick(0, 0, 1, 32'h5000, o);
    for (int c = 0; c < 20 && !got; c++) begin
      tick(0, 0, 0, 32'h0, o);
      if (o.popped) begin
        got = 1;
        n_assert++;
        if (o.instr !== mem_word(32'h5000) || o.pc4 !== 32'h5004 || o.adel !== 1'b0) begin
          n_fail++; $display("FAIL adel_resume: instr=%h pc4=%h adel=%b expected %h/00005004/0", o.instr, o.pc4, o.adel, mem_word(32'h5000));
        end
      end
    end
    n_assert++; if (!got) begin n_fail++; $display("FAIL adel_timeout: valid seen=%0d expected 1", got); end
  endtask
`endif

  task automatic test_protocol();
    n_assert++; if (proto_err !== 0) begin n_fail++; $display("FAIL one_outstanding: violations=%0d expected 0", proto_err); end
    n_assert++; if (hold_err !== 0) begin n_fail++; $display("FAIL req_stable: violations=%0d expected 0", hold_err); end
    n_assert++; if (bubble_err !== 0) begin n_fail++; $display("FAIL nop_bubble: violations=%0d expected 0", bubble_err); end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_gnt_low();
    test_redirect_outstanding();
    test_wrap();
    test_back_to_back();
`ifdef FETCH_ALIGN_CHECK_EN
    test_align();
`endif
    test_random();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-003 imem_req  output  1  instruction-memory request valid.
REQ-004 imem_addr  output  32  word address of request (byte address, bits 1:0 = 0 when aligned).
REQ-005 imem_gnt  input  1  memory accepts request this cycle (req & gnt = handshake).
REQ-006 imem_rvalid  input  1  read data valid; exactly one per granted request, in order, >=1 cycle after grant.
REQ-007 imem_rdata  input  32  instruction word.
REQ-008 stall  input  1  decode-side hold; high = IF/ID register not loading this cycle.
REQ-009 redirect  input  1  branch/jump/exception taken; restart fetch at redirect_pc.
REQ-010 redirect_pc  input  32  new fetch address.
REQ-011 instr_out  output  32  instruction to IF/ID register (IR input).
REQ-012 pc4_out  output  32  address of instr_out plus 4 (PC4 input).
REQ-013 instr_valid  output  1  instr_out/pc4_out hold a real instruction.
REQ-014 adel_out  output  1  fetch address misaligned (present only with FETCH_ALIGN_CHECK_EN).

Function
REQ-015 Fetch PC register shall hold next address to request; increments by 4 on every handshake.
REQ-016 At most one request shall be outstanding (granted, rvalid not yet seen).
REQ-017 imem_req shall assert only when no request is outstanding and FIFO occupancy + outstanding < 2.
REQ-018 Once asserted without gnt, imem_req and imem_addr shall stay stable until gnt, except on redirect.
REQ-019 A 2-entry FIFO shall store {imem_rdata, request_addr+4} on each non-discarded rvalid.
REQ-020 instr_out/pc4_out shall be combinational from FIFO head; instr_valid = FIFO non-empty.
REQ-021 FIFO empty: instr_out = 32'h0 (NOP bubble), pc4_out = fetch PC + 4, instr_valid = 0.
REQ-022 Pop shall occur when instr_valid & !stall; push and pop in same cycle shall leave occupancy unchanged.
REQ-023 FIFO full: no new request issued; rvalid cannot arrive (REQ-017 guarantees).
REQ-024 Minimum latency: grant at cycle N, rvalid at N+1, instr_valid at N+2.
REQ-025 redirect: FIFO flushed, fetch PC <= redirect_pc, pending ungranted request withdrawn; new request from redirect_pc no earlier than next cycle.
REQ-026 redirect with request outstanding: that response shall be discarded (drop flag set, cleared on its rvalid); no request issued until drop clears.
REQ-027 redirect coincident with rvalid: response discarded; redirect coincident with gnt: granted request marked for discard.
REQ-028 redirect has priority over stall and pop; instr_valid = 0 the cycle after redirect.
REQ-029 PC arithmetic 32-bit, wraps 32'hFFFFFFFC -> 32'h00000000 silently.

Reset
REQ-030 On reset: fetch PC = 32'h00003000, FIFO empty, outstanding = 0, drop = 0, imem_req = 0, instr_valid = 0, instr_out = 0, adel_out = 0.
REQ-031 Reset overrides redirect; responses arriving during or after reset for pre-reset requests shall be discarded.
REQ-032 First request issued the cycle after reset deasserts, address 32'h00003000.

Configuration
REQ-033 Macro FETCH_ALIGN_CHECK_EN defined: redirect_pc[1:0] != 0 sets fetch address without issuing request, pushes one FIFO entry instr 32'h0 with adel_out = 1 for that entry; fetch halts until next redirect.
REQ-034 Macro undefined: adel_out port absent, imem_addr[1:0] forced to 0, no alignment check.

Verification
REQ-035 Reset, gnt=1 always, rvalid 1 cycle after grant, stall=0 -> instr_out words from 0x3000, 0x3004, 0x3008 with pc4_out 0x3004/0x3008/0x300C, no gaps after pipeline fill.
REQ-036 stall=1 for 5 cycles mid-stream -> FIFO fills to 2, imem_req drops, instr_out held; release -> order preserved, no loss or duplicate.
REQ-037 redirect to 0x4000 while request to 0x3008 outstanding -> 0x3008 data dropped, next instr_valid shows 0x4000 data with pc4_out 0x4004.
REQ-038 gnt held low 4 cycles -> imem_addr stable at 0x3000, instr_valid = 0, instr_out = 0.
REQ-039 redirect to 0xFFFFFFFC -> fetches 0xFFFFFFFC then 0x00000000 (pc4_out 0x00000000 then 0x00000004).
REQ-040 With FETCH_ALIGN_CHECK_EN, redirect to 0x4002 -> no imem_req, instr_valid = 1, instr_out = 0, adel_out = 1; redirect to 0x5000 resumes normally.
